// File: rtl/prim_util_pkg_u.sv
// Shared utility functions for index-width computation.
package prim_util_pkg_u;

    // Bits needed to index a vector of the given size; a single entry still takes one bit.
    function automatic int unsigned vbits(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/uart_tx_arb_pkg.sv
// Types and constants for the UART TX round-robin packet arbiter.
package uart_tx_arb_pkg;
    import prim_util_pkg_u::*;

    localparam int unsigned MaxNumReq = 16;
    localparam int unsigned MaxIdxW   = vbits(MaxNumReq);

    // Source-tag byte; the granted index is OR-ed into the low nibble.
    localparam logic [7:0] TagBase = 8'hA0;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StTag  = 2'b01,
        StLock = 2'b10
    } state_e;

endpackage

// File: rtl/uart_tx_rr_pick.sv
// Combinational rotate-priority picker: first set request at or above ptr_i, wrapping.
module uart_tx_rr_pick
    import prim_util_pkg_u::*;
#(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdxW   = vbits(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;

    // Scan NumReq candidates starting at the pointer; the mod keeps every index in range.
    always_comb begin
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = 32'(ptr_i) + i;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            cand_idx = IdxW'(cand);
            if (!valid_o && req_i[cand_idx]) begin
                idx_o   = cand_idx;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_rr_arb.sv
// Round-robin packet arbiter sharing the UART TX byte channel among NumReq requesters.
// Optional source-tag byte before each packet when UART_TX_ARB_TAG_EN is defined.
module uart_tx_rr_arb
    import uart_tx_arb_pkg::*;
    import prim_util_pkg_u::*;
#(
    parameter int unsigned NumReq = 4,
    parameter int unsigned DataW  = 8,
    localparam int unsigned IdxW  = vbits(NumReq)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumReq-1:0]       req_valid_i,
    input  logic [NumReq*DataW-1:0] req_data_i,
    input  logic [NumReq-1:0]       req_last_i,
    output logic [NumReq-1:0]       req_ready_o,
    output logic                    tx_valid_o,
    output logic [DataW-1:0]        tx_data_o,
    output logic                    tx_last_o,
    input  logic                    tx_ready_i,
    output logic [IdxW-1:0]         gnt_idx_o,
    output logic                    busy_o
);

    if (NumReq < 1 || NumReq > MaxNumReq || IdxW > MaxIdxW) begin : gen_num_req_check
        $error("uart_tx_rr_arb: NumReq must be within 1..16");
    end

    state_e          state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] gnt_q, gnt_d;
    logic [IdxW-1:0] pick_idx;
    logic            pick_valid;
    logic [DataW-1:0] req_data_arr [NumReq];

    // Unpack the flat byte bus so the granted lane is a plain array index.
    always_comb begin
        for (int unsigned k = 0; k < NumReq; k++) begin
            req_data_arr[k] = req_data_i[k*DataW +: DataW];
        end
    end

    uart_tx_rr_pick #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_pick (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // State, round-robin pointer and grant registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
        end
    end

    // Next-state and output decode; outputs are idle except while a grant is held.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        busy_o      = 1'b0;
        tx_valid_o  = 1'b0;
        tx_data_o   = '0;
        tx_last_o   = 1'b0;
        req_ready_o = '0;
        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    gnt_d = pick_idx;
`ifdef UART_TX_ARB_TAG_EN
                    state_d = StTag;
`else
                    state_d = StLock;
`endif
                end
            end
`ifdef UART_TX_ARB_TAG_EN
            StTag: begin
                busy_o     = 1'b1;
                tx_valid_o = 1'b1;
                tx_data_o  = DataW'(TagBase) | DataW'(gnt_q);
                if (tx_ready_i) begin
                    state_d = StLock;
                end
            end
`endif
            StLock: begin
                busy_o              = 1'b1;
                tx_valid_o          = req_valid_i[gnt_q];
                tx_data_o           = req_data_arr[gnt_q];
                tx_last_o           = req_last_i[gnt_q];
                req_ready_o[gnt_q]  = tx_ready_i;
                if (tx_valid_o && tx_ready_i && tx_last_o) begin
                    ptr_d   = (gnt_q == IdxW'(NumReq - 1)) ? '0 : gnt_q + 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign gnt_idx_o = gnt_q;

endmodule

// File: tb/tb_uart_tx_rr_arb.sv
// Self-checking bench for uart_tx_rr_arb: directed cases plus randomized packet traffic
// checked against a queue-based round-robin packet model.
module tb_uart_tx_rr_arb;

`ifdef UART_TX_ARB_TAG_EN
    localparam bit TagEn = 1'b1;
`else
    localparam bit TagEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic        tx_ready = 1'b0;
    logic [3:0]  req_ready_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_last_o;
    logic [1:0]  gnt_idx_o;
    logic        busy_o;

    // Three-requester instance for the non-power-of-two wrap case.
    logic [2:0]  v3 = '0;
    logic [23:0] d3 = '0;
    logic [2:0]  l3 = '0;
    logic        rdy3 = 1'b0;
    logic [2:0]  rr3;
    logic        txv3;
    logic [7:0]  txd3;
    logic        txl3;
    logic [1:0]  gnt3;
    logic        busy3;

    int vectors = 0;
    int miscompares = 0;
    int cyc_cnt = 0;

    uart_tx_rr_arb #(.NumReq(4), .DataW(8)) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready_o),
        .tx_valid_o  (tx_valid_o),
        .tx_data_o   (tx_data_o),
        .tx_last_o   (tx_last_o),
        .tx_ready_i  (tx_ready),
        .gnt_idx_o   (gnt_idx_o),
        .busy_o      (busy_o)
    );

    uart_tx_rr_arb #(.NumReq(3), .DataW(8)) u_dut3 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (v3),
        .req_data_i  (d3),
        .req_last_i  (l3),
        .req_ready_o (rr3),
        .tx_valid_o  (txv3),
        .tx_data_o   (txd3),
        .tx_last_o   (txl3),
        .tx_ready_i  (rdy3),
        .gnt_idx_o   (gnt3),
        .busy_o      (busy3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Packet store per requester and driver progress.
    int         npk [4];
    int         plen [4][8];
    logic [7:0] pdat [4][8][8];
    int         cur_pk [4];
    int         cur_by [4];
    bit         rnd_gap, rnd_ready, chk_timing;
    int         stall_req, stall_left;

    logic [7:0] exp_d[$];
    bit         exp_l[$];
    int         exp_s[$];
    logic [7:0] obs_d[$];
    bit         obs_l[$];
    int         obs_s[$];
    int         obs_c[$];
    int         order3[$];
    int         max3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_pkts();
        for (int k = 0; k < 4; k++) begin
            npk[k] = 0;
        end
        rnd_gap = 0; rnd_ready = 0; chk_timing = 0; stall_req = -1; stall_left = 0;
    endtask

    task automatic add_rand_pkt(input int k, input int len);
        plen[k][npk[k]] = len;
        for (int b = 0; b < len; b++) pdat[k][npk[k]][b] = 8'($urandom);
        npk[k]++;
    endtask

    // Packet-level reference: whole packets in round-robin order from pointer 0.
    task automatic build_model();
        int taken [4];
        int ptr;
        int w;
        exp_d.delete(); exp_l.delete(); exp_s.delete();
        for (int k = 0; k < 4; k++) taken[k] = 0;
        ptr = 0;
        while (1) begin
            w = -1;
            for (int i = 0; i < 4; i++) begin
                if (w < 0 && taken[(ptr + i) % 4] < npk[(ptr + i) % 4]) w = (ptr + i) % 4;
            end
            if (w < 0) break;
            if (TagEn) begin
                exp_d.push_back(8'hA0 | 8'(w)); exp_l.push_back(1'b0); exp_s.push_back(w);
            end
            for (int b = 0; b < plen[w][taken[w]]; b++) begin
                exp_d.push_back(pdat[w][taken[w]][b]);
                exp_l.push_back(b == plen[w][taken[w]] - 1);
                exp_s.push_back(w);
            end
            taken[w]++;
            ptr = (w + 1) % 4;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '1; req_last = '1; req_data = $urandom; tx_ready = 1'b1;
        v3 = '1; l3 = '1; rdy3 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_tx_valid", tx_valid_o, 0);
        check("rst_req_ready", req_ready_o, 0);
        check("rst_gnt_idx", gnt_idx_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_tx_last", tx_last_o, 0);
        check("rst_tx_data", tx_data_o, 0);
        req_valid = '0; req_last = '0; v3 = '0; l3 = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_engine(input string name, input int budget);
        bit v, stalling;
        build_model();
        obs_d.delete(); obs_l.delete(); obs_s.delete(); obs_c.delete();
        for (int k = 0; k < 4; k++) begin cur_pk[k] = 0; cur_by[k] = 0; end
        for (int c = 0; c < budget && obs_d.size() < exp_d.size(); c++) begin
            @(negedge clk);
            stalling = 0;
            for (int k = 0; k < 4; k++) begin
                v = 0;
                req_data[k*8 +: 8] = 8'($urandom);
                req_last[k] = 1'($urandom);
                if (cur_pk[k] < npk[k]) begin
                    v = 1;
                    if (cur_by[k] > 0 && rnd_gap && ($urandom % 4 == 0)) v = 0;
                    if (k == stall_req && stall_left > 0 && cur_pk[k] == 0 && cur_by[k] == 1) begin
                        v = 0; stall_left--; stalling = 1;
                    end
                    req_data[k*8 +: 8] = pdat[k][cur_pk[k]][cur_by[k]];
                    req_last[k] = (cur_by[k] == plen[k][cur_pk[k]] - 1);
                end
                req_valid[k] = v;
            end
            tx_ready = rnd_ready ? ($urandom % 4 != 0) : 1'b1;
            #1;
            check({name, "_ready_onehot0"}, 32'($countones(req_ready_o) <= 1), 1);
            if (stalling) begin
                check({name, "_stall_tx_valid"}, tx_valid_o, 0);
                check({name, "_stall_gnt"}, gnt_idx_o, 2'(stall_req));
                check({name, "_stall_ready3"}, req_ready_o[3], 0);
            end
            if (tx_valid_o && tx_ready) begin
                obs_d.push_back(tx_data_o); obs_l.push_back(tx_last_o);
                obs_s.push_back(int'(gnt_idx_o)); obs_c.push_back(cyc_cnt);
            end
            for (int k = 0; k < 4; k++) begin
                if (req_valid[k] && req_ready_o[k]) begin
                    cur_by[k]++;
                    if (cur_by[k] >= plen[k][cur_pk[k]]) begin cur_pk[k]++; cur_by[k] = 0; end
                end
            end
        end
        @(negedge clk);
        req_valid = '0; tx_ready = 1'b1;
        #1;
        check({name, "_byte_count"}, obs_d.size(), exp_d.size());
        check({name, "_idle_after"}, busy_o, 0);
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            check($sformatf("%s_data[%0d]", name, i), obs_d[i], exp_d[i]);
            check($sformatf("%s_last[%0d]", name, i), obs_l[i], exp_l[i]);
            check($sformatf("%s_src[%0d]", name, i), obs_s[i], exp_s[i]);
        end
        if (chk_timing) begin
            for (int i = 0; i + 1 < obs_c.size(); i++) begin
                check($sformatf("%s_gap[%0d]", name, i), obs_c[i+1] - obs_c[i], obs_l[i] ? 2 : 1);
            end
        end
    endtask

    task automatic run3(input logic [2:0] mask, input int budget);
        logic [2:0] pend;
        pend = mask;
        for (int c = 0; c < budget && pend != 0; c++) begin
            @(negedge clk);
            v3 = pend; d3 = {8'h32, 8'h31, 8'h30}; l3 = 3'b111; rdy3 = 1'b1;
            #1;
            if (int'(gnt3) > max3) max3 = int'(gnt3);
            if (txv3 && rdy3 && txl3) order3.push_back(int'(gnt3));
            pend = pend & ~(v3 & rr3);
        end
        @(negedge clk);
        v3 = '0;
        check("r3_done", pend, 0);
    endtask

    initial begin
        // Reset with every requester asserting valid.
        do_reset();

        // Single requester 2, three bytes, back-to-back.
        clear_pkts();
        plen[2][0] = 3; pdat[2][0][0] = 8'h11; pdat[2][0][1] = 8'h22; pdat[2][0][2] = 8'h33;
        npk[2] = 1; chk_timing = 1;
        run_engine("single", 50);

        // All four requesters with two one-byte packets each.
        do_reset();
        clear_pkts();
        for (int k = 0; k < 4; k++) begin add_rand_pkt(k, 1); add_rand_pkt(k, 1); end
        chk_timing = 1;
        run_engine("rr4", 100);

        // Requester 1 stalls mid-packet while requester 3 waits.
        do_reset();
        clear_pkts();
        add_rand_pkt(1, 4); add_rand_pkt(3, 2);
        stall_req = 1; stall_left = 3;
        run_engine("sticky", 100);
        check("sticky_stall_used", stall_left, 0);

        // First-byte latency (and tag byte with backpressure when enabled).
        do_reset();
        @(negedge clk);
        req_valid = 4'b0010; req_data = 32'h0000_5500; req_last = 4'b0010; tx_ready = 1'b0;
        #1;
        check("lat_bubble_valid", tx_valid_o, 0);
`ifdef UART_TX_ARB_TAG_EN
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check("tag_valid", tx_valid_o, 1);
            check("tag_data", tx_data_o, 8'hA1);
            check("tag_last", tx_last_o, 0);
            check("tag_ready", req_ready_o, 0);
        end
        @(negedge clk);
        tx_ready = 1'b1;
        #1;
        check("tag_data_release", tx_data_o, 8'hA1);
`else
        tx_ready = 1'b1;
`endif
        @(negedge clk);
        #1;
        check("first_valid", tx_valid_o, 1);
        check("first_data", tx_data_o, 8'h55);
        check("first_last", tx_last_o, 1);
        check("first_ready", req_ready_o, 4'b0010);
        check("first_gnt", gnt_idx_o, 1);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("first_idle", busy_o, 0);
        check("first_gnt_hold", gnt_idx_o, 1);

        // Asynchronous reset in the middle of a packet.
        @(negedge clk);
        req_valid = 4'b0001; req_data = 32'h0000_00AB; req_last = 4'b0000;
        @(negedge clk);
        #1;
        check("abort_busy_before", busy_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy_o, 0);
        check("abort_tx_valid", tx_valid_o, 0);
        check("abort_req_ready", req_ready_o, 0);
        check("abort_gnt", gnt_idx_o, 0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Three requesters: pointer parked at 2, then requests {0,2}.
        do_reset();
        order3.delete(); max3 = 0;
        run3(3'b010, 30);
        run3(3'b101, 60);
        check("r3_count", order3.size(), 3);
        if (order3.size() == 3) begin
            check("r3_first", order3[0], 1);
            check("r3_second", order3[1], 2);
            check("r3_third", order3[2], 0);
        end
        check("r3_range", 32'(max3 < 3), 1);

        // Randomized traffic with mid-packet gaps and TX backpressure.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            clear_pkts();
            for (int k = 0; k < 4; k++) begin
                int n;
                n = $urandom_range(3, 0);
                for (int p = 0; p < n; p++) add_rand_pkt(k, $urandom_range(5, 1));
            end
            rnd_gap = 1; rnd_ready = 1;
            run_engine($sformatf("rand%0d", r), 2000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
